// File: rtl/bin2bcd_seq.sv
// Sequential 32-bit binary to 8-digit packed BCD converter (double dabble, one bit per clock).
// Fixed 34-cycle cadence; results held stable between done pulses, optional saturation on overflow.
module bin2bcd_seq #(
  parameter bit SAT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] bin,
  output logic        busy,
  output logic        done,
  output logic [31:0] bcd,
  output logic        ovf
);

  localparam logic [31:0] MAX_DEC = 32'd99_999_999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [4:0]  cnt_reg, cnt_next;
  logic [31:0] sr_reg, sr_next;
  logic [39:0] acc_reg, acc_next;
  logic        ovf_pend_reg, ovf_pend_next;
  logic [31:0] bcd_reg, bcd_next;
  logic        ovf_reg, ovf_next;
  logic        done_reg, done_next;
  logic        busy_reg, busy_next;
  logic [39:0] acc_adj;

  // Per-digit add-3 correction ahead of the shift keeps every digit within 0-9.
  generate
    for (genvar gi = 0; gi < 10; gi++) begin : g_adj
      assign acc_adj[gi*4 +: 4] = (acc_reg[gi*4 +: 4] >= 4'd5) ?
                                  acc_reg[gi*4 +: 4] + 4'd3 : acc_reg[gi*4 +: 4];
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    sr_next       = sr_reg;
    acc_next      = acc_reg;
    ovf_pend_next = ovf_pend_reg;
    bcd_next      = bcd_reg;
    ovf_next      = ovf_reg;
    done_next     = 1'b0;
    busy_next     = busy_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next    = SHIFT;
          sr_next       = bin;
          acc_next      = 40'd0;
          cnt_next      = 5'd0;
          ovf_pend_next = (bin > MAX_DEC);
          busy_next     = 1'b1;
        end
      end
      SHIFT: begin
        acc_next = {acc_adj[38:0], sr_reg[31]};
        sr_next  = {sr_reg[30:0], 1'b0};
        cnt_next = cnt_reg + 5'd1;
        if (cnt_reg == 5'd31) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done_next  = 1'b1;
        bcd_next   = (SAT && ovf_pend_reg) ? 32'h9999_9999 : acc_reg[31:0];
        ovf_next   = ovf_pend_reg;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= 5'd0;
      sr_reg       <= 32'd0;
      acc_reg      <= 40'd0;
      ovf_pend_reg <= 1'b0;
      bcd_reg      <= 32'd0;
      ovf_reg      <= 1'b0;
      done_reg     <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      sr_reg       <= sr_next;
      acc_reg      <= acc_next;
      ovf_pend_reg <= ovf_pend_next;
      bcd_reg      <= bcd_next;
      ovf_reg      <= ovf_next;
      done_reg     <= done_next;
      busy_reg     <= busy_next;
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign bcd  = bcd_reg;
  assign ovf  = ovf_reg;

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter: SAT, default 1, 1 = saturate on overflow, 0 = output value modulo 10^8.
REQ-002 SHALL have port: clk  input  1  single system clock, all logic on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request conversion of bin; sampled on rising clk.
REQ-005 SHALL have port: bin  input  32  unsigned binary operand, captured when start is accepted.
REQ-006 SHALL have port: busy  output  1  high while a conversion is in progress.
REQ-007 SHALL have port: done  output  1  one-cycle pulse when bcd/ovf are updated.
REQ-008 SHALL have port: bcd  output  32  8 packed BCD digits, digit0 in [3:0] through digit7 in [31:28], feeds the 8-digit display scanner.
REQ-009 SHALL have port: ovf  output  1  set when the captured bin exceeds 99,999,999.

Function
REQ-010 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-011 SHALL transition IDLE->SHIFT on start=1: capture bin into a 32-bit shift register, clear a 40-bit (10-digit) BCD accumulator, load iteration counter to 0, and latch ovf_next = (bin > 99,999,999).
REQ-012 SHALL perform one double-dabble iteration per cycle in SHIFT: add 3 to every accumulator digit >= 5, then shift {accumulator, shift register} left by 1.
REQ-013 SHALL stay in SHIFT for exactly 32 cycles; counter 31 -> DONE.
REQ-014 SHALL in the DONE cycle assert done=1 for exactly one cycle, update bcd and ovf in that same cycle, then go to IDLE.
REQ-015 SHALL set bcd on update to 32'h99999999 when SAT=1 and ovf_next=1, else to the low 8 digits of the accumulator.
REQ-016 SHALL give a fixed latency: start accepted at edge N -> done=1 and new bcd visible after edge N+33; independent of operand value.
REQ-017 SHALL drive busy=1 from the edge accepting start through the DONE cycle inclusive; busy=0 in IDLE.
REQ-018 SHALL ignore start while busy=1 (SHIFT or DONE); operand and progress unaffected.
REQ-019 SHALL accept start in IDLE the cycle after DONE, allowing back-to-back conversions every 34 cycles.
REQ-020 SHALL hold bcd and ovf stable between done pulses; intermediate accumulator values never appear on bcd.
REQ-021 SHALL not register bin outside the accept cycle; bin changes during SHIFT have no effect.
REQ-022 SHALL keep every digit of the accumulator in range 0-9 after each iteration; no carry out of digit 9 occurs for 32-bit inputs.

Reset
REQ-023 SHALL on reset=1 at a rising edge force state=IDLE, busy=0, done=0, bcd=32'h0, ovf=0, and clear the counter and internal registers.
REQ-024 SHALL abort any conversion in progress when reset is asserted, with no done pulse and no bcd update.
REQ-025 SHALL give reset priority over start in the same cycle.

Verification
REQ-026 SHALL cover: reset asserted 2 cycles -> bcd=32'h00000000, busy=0, done=0, ovf=0.
REQ-027 SHALL cover: bin=32'd12345678, start 1 cycle -> done pulse 33 cycles later, bcd=32'h12345678, ovf=0, busy high 33 cycles.
REQ-028 SHALL cover: bin=0 -> bcd=32'h00000000; bin=32'd99999999 -> bcd=32'h99999999, ovf=0.
REQ-029 SHALL cover: SAT=1, bin=32'd100000000 -> bcd=32'h99999999, ovf=1; SAT=0, bin=32'hFFFFFFFF (4294967295) -> bcd=32'h94967295, ovf=1.
REQ-030 SHALL cover: start pulsed with bin=32'd5 at cycle 10 of a conversion of 32'd42 -> result bcd=32'h00000042, single done, then new start converts 5 -> 32'h00000005.
REQ-031 SHALL cover: reset at SHIFT cycle 10 of bin=32'd87654321 -> no done, bcd=0, busy=0; subsequent start of 32'd7 -> bcd=32'h00000007 after 33 cycles.
